// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : noc_pkg
// Purpose : Shared NoC definitions: destination field width, destination
//           extraction helper and default parameter values used by the
//           spine_ni_bridge and enhanced_router blocks.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam int DEST_W     = 6;
  localparam int FLIT_MAX_W = 64;

  localparam int                DEF_DWIDTH     = 16;
  localparam int                DEF_NUM_SPINES = 4;
  localparam int                DEF_FIFO_DEPTH = 4;
  localparam int                DEF_CREDITS    = 4;
  localparam logic [DEST_W-1:0] DEF_LOCAL_ID   = 6'd21;

  typedef logic [DEST_W-1:0] dest_t;

  // The destination is always the top DEST_W bits of a flit, whatever the
  // flit width. Flits are zero-extended to FLIT_MAX_W by the caller.
  function automatic dest_t flit_dest(input logic [FLIT_MAX_W-1:0] flit,
                                      input int unsigned           dwidth);
    logic [FLIT_MAX_W-1:0] w_sh;
    w_sh = flit >> (dwidth - DEST_W);
    return w_sh[DEST_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_flit_fifo.sv
`default_nettype none
// ============================================================================
// Module  : noc_flit_fifo
// Purpose : Single-clock flit FIFO, DEPTH entries (power of 2, >= 2).
// Ports   : clk/rst_n   - clock, synchronous active-low reset
//           push/din    - write strobe and data (caller ensures room)
//           pop         - read strobe, advances head when not empty
//           full/empty  - occupancy flags
//           dout        - head-of-queue data (valid when !empty)
// Rev     : 1.0 - initial release
// ============================================================================
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DWIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_cnt;
  logic              w_do_pop;
  logic              w_do_push;

  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign dout      = r_mem[r_rptr];
  assign w_do_pop  = pop && !empty;
  // A push while full is legal only when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  // Storage is not reset; emptiness is carried entirely by r_cnt.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spine_ni_bridge.sv
`default_nettype none
// ============================================================================
// Module  : spine_ni_bridge
// Purpose : Network interface between a GPU port and NUM_SPINES spine links.
//           Egress flits are routed by destination to a credit-controlled
//           spine (1-cycle registered) or to a 1-flit loopback slot. Ingress
//           flits are buffered per spine and round-robin arbitrated, together
//           with the loopback slot, into a 1-entry gpu_out register.
// Ports   : ACLK, ARESETn             - clock, synchronous active-low reset
//           gpu_in_*                  - egress valid/ready flit stream
//           gpu_out_*                 - delivered valid/ready flit stream
//           spine_out_data/valid      - per-spine egress flits (slice i)
//           spine_credit_in           - per-spine credit return pulses
//           spine_in_data/valid       - per-spine ingress flits, no backpressure
//           spine_credit_out          - pulse when ingress FIFO i is popped
//           err_status                - sticky {0, credit ovf, ingress ovf}
// Rev     : 1.0 - initial release
// ============================================================================
module spine_ni_bridge
  import noc_pkg::*;
#(
  parameter int          DWIDTH     = DEF_DWIDTH,
  parameter int          NUM_SPINES = DEF_NUM_SPINES,
  parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int          CREDITS    = DEF_CREDITS,
  parameter logic [5:0]  LOCAL_ID   = DEF_LOCAL_ID
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [DWIDTH-1:0]            gpu_in_data,
  input  logic                         gpu_in_valid,
  output logic                         gpu_in_ready,
  output logic [DWIDTH-1:0]            gpu_out_data,
  output logic                         gpu_out_valid,
  input  logic                         gpu_out_ready,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_credit_in,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES-1:0]        spine_credit_out,
  output logic [2:0]                   err_status
);

  localparam int                SPW    = $clog2(NUM_SPINES);
  localparam int                NREQ   = NUM_SPINES + 1;
  localparam int                ARB_W  = $clog2(NREQ);
  localparam int                CW     = $clog2(CREDITS + 1);
  localparam logic [ARB_W-1:0]  LB_IDX = ARB_W'(NUM_SPINES);

  // Egress routing
  dest_t                              w_dest;
  logic                               w_is_lb;
  logic [SPW-1:0]                     w_tgt;
  logic                               w_fire;
  logic [NUM_SPINES-1:0]              w_send;
  logic [CW-1:0]                      r_cred [NUM_SPINES];
  logic [NUM_SPINES-1:0]              w_cred_ovf;
  logic [NUM_SPINES-1:0]              r_sp_vld;
  logic [NUM_SPINES-1:0][DWIDTH-1:0]  r_sp_data;

  // Ingress buffering and arbitration
  logic [NUM_SPINES-1:0]              w_full;
  logic [NUM_SPINES-1:0]              w_empty;
  logic [NUM_SPINES-1:0]              w_push;
  logic [NUM_SPINES-1:0]              w_pop;
  logic [NUM_SPINES-1:0]              w_drop;
  logic [NUM_SPINES-1:0][DWIDTH-1:0]  w_fifo_dout;
  logic                               r_lb_vld;
  logic [DWIDTH-1:0]                  r_lb_data;
  logic                               w_lb_pop;
  logic [NREQ-1:0]                    w_req;
  logic [ARB_W-1:0]                   r_ptr;
  logic [ARB_W:0]                     w_cand;
  logic                               w_gnt_any;
  logic [ARB_W-1:0]                   w_gnt_idx;
  logic                               w_grant;
  logic [DWIDTH-1:0]                  w_gnt_data;
  logic                               r_out_vld;
  logic [DWIDTH-1:0]                  r_out_data;
  logic [1:0]                         r_err;

  assign w_dest  = flit_dest(FLIT_MAX_W'(gpu_in_data), DWIDTH);
  assign w_is_lb = (w_dest == LOCAL_ID);
  assign w_tgt   = w_dest[SPW-1:0];

  // The loopback slot may take a new flit in the same cycle it is drained.
  assign gpu_in_ready = ARESETn &&
                        (w_is_lb ? (!r_lb_vld || w_lb_pop) : (r_cred[w_tgt] != '0));
  assign w_fire       = gpu_in_valid && gpu_in_ready;

  always_comb begin
    w_send     = '0;
    w_cred_ovf = '0;
    for (int i = 0; i < NUM_SPINES; i++) begin
      w_send[i]     = w_fire && !w_is_lb && (w_tgt == SPW'(i));
      // A return that coincides with a send is absorbed, never an overflow.
      w_cred_ovf[i] = spine_credit_in[i] && !w_send[i] && (r_cred[i] == CW'(CREDITS));
    end
  end

  always_ff @(posedge ACLK) begin
    for (int i = 0; i < NUM_SPINES; i++) begin
      if (!ARESETn)
        r_cred[i] <= CW'(CREDITS);
      else if (w_send[i] && !spine_credit_in[i])
        r_cred[i] <= r_cred[i] - CW'(1);
      else if (spine_credit_in[i] && !w_send[i] && !w_cred_ovf[i])
        r_cred[i] <= r_cred[i] + CW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SPINES; gi++) begin : g_spine
      assign w_pop[gi]  = w_grant && (w_gnt_idx == ARB_W'(gi));
      assign w_push[gi] = spine_in_valid[gi] && (!w_full[gi] || w_pop[gi]);
      assign w_drop[gi] = spine_in_valid[gi] && w_full[gi] && !w_pop[gi];

      noc_flit_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (w_push[gi]),
        .din   (spine_in_data[gi*DWIDTH +: DWIDTH]),
        .pop   (w_pop[gi]),
        .full  (w_full[gi]),
        .empty (w_empty[gi]),
        .dout  (w_fifo_dout[gi])
      );
    end
  endgenerate

  assign w_req = {r_lb_vld, ~w_empty};

  // Round-robin: first requester at or after r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + (ARB_W+1)'(k);
      if (w_cand >= (ARB_W+1)'(NREQ)) w_cand = w_cand - (ARB_W+1)'(NREQ);
      if (!w_gnt_any && w_req[w_cand[ARB_W-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand[ARB_W-1:0];
      end
    end
  end

  assign w_grant    = ARESETn && w_gnt_any && (!r_out_vld || gpu_out_ready);
  assign w_lb_pop   = w_grant && (w_gnt_idx == LB_IDX);
  assign w_gnt_data = (w_gnt_idx == LB_IDX) ? r_lb_data : w_fifo_dout[w_gnt_idx[SPW-1:0]];

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_sp_vld   <= '0;
      r_sp_data  <= '0;
      r_lb_vld   <= 1'b0;
      r_lb_data  <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_ptr      <= '0;
      r_err      <= '0;
    end else begin
      r_sp_vld <= w_send;
      if (w_fire && !w_is_lb) r_sp_data[w_tgt] <= gpu_in_data;

      // A refill in the drain cycle wins: the old flit was read this cycle.
      if (w_fire && w_is_lb) begin
        r_lb_vld  <= 1'b1;
        r_lb_data <= gpu_in_data;
      end else if (w_lb_pop) begin
        r_lb_vld  <= 1'b0;
      end

      if (w_grant) begin
        r_out_vld  <= 1'b1;
        r_out_data <= w_gnt_data;
        r_ptr      <= (w_gnt_idx == LB_IDX) ? '0 : w_gnt_idx + ARB_W'(1);
      end else if (gpu_out_ready) begin
        r_out_vld  <= 1'b0;
      end

      r_err[0] <= r_err[0] | (|w_drop);
      r_err[1] <= r_err[1] | (|w_cred_ovf);
    end
  end

  assign spine_out_valid  = r_sp_vld;
  assign spine_out_data   = r_sp_data;
  assign spine_credit_out = w_pop;
  assign gpu_out_valid    = r_out_vld;
  assign gpu_out_data     = r_out_data;
  assign err_status       = {1'b0, r_err};

endmodule
`default_nettype wire

// File: tb/tb_spine_ni_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_spine_ni_bridge
// Purpose : Self-checking bench for spine_ni_bridge (default parameters):
//           routing vector table, directed multi-cycle sequences and a
//           randomized run against a queue/credit reference model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_spine_ni_bridge;

  localparam int DW      = 16;
  localparam int NS      = 4;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic           ACLK = 1'b0;
  logic           ARESETn;
  logic [DW-1:0]  gpu_in_data;
  logic           gpu_in_valid;
  logic           gpu_in_ready;
  logic [DW-1:0]  gpu_out_data;
  logic           gpu_out_valid;
  logic           gpu_out_ready;
  logic [NS*DW-1:0] spine_out_data;
  logic [NS-1:0]  spine_out_valid;
  logic [NS-1:0]  spine_credit_in;
  logic [NS*DW-1:0] spine_in_data;
  logic [NS-1:0]  spine_in_valid;
  logic [NS-1:0]  spine_credit_out;
  logic [2:0]     err_status;

  spine_ni_bridge dut (
    .ACLK             (ACLK),
    .ARESETn          (ARESETn),
    .gpu_in_data      (gpu_in_data),
    .gpu_in_valid     (gpu_in_valid),
    .gpu_in_ready     (gpu_in_ready),
    .gpu_out_data     (gpu_out_data),
    .gpu_out_valid    (gpu_out_valid),
    .gpu_out_ready    (gpu_out_ready),
    .spine_out_data   (spine_out_data),
    .spine_out_valid  (spine_out_valid),
    .spine_credit_in  (spine_credit_in),
    .spine_in_data    (spine_in_data),
    .spine_in_valid   (spine_in_valid),
    .spine_credit_out (spine_credit_out),
    .err_status       (err_status)
  );

  always #5 ACLK = ~ACLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic smp();
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    gpu_in_data     = '0;
    gpu_in_valid    = 1'b0;
    gpu_out_ready   = 1'b0;
    spine_credit_in = '0;
    spine_in_data   = '0;
    spine_in_valid  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESETn = 1'b0;
    step();
    step();
    ARESETn = 1'b1;
  endtask

  // Offer flits to one destination for ncyc cycles; count accepts and the
  // resulting spine_out_valid pulses on the routed spine.
  task automatic send_burst(input logic [5:0] dest, input int ncyc,
                            output int nfire, output int npulse);
    nfire  = 0;
    npulse = 0;
    for (int k = 0; k < ncyc; k++) begin
      step();
      gpu_in_valid = 1'b1;
      gpu_in_data  = {dest, 10'(nfire)};
      smp();
      if (spine_out_valid[dest[1:0]]) npulse++;
      if (gpu_in_ready) nfire++;
    end
    step();
    gpu_in_valid = 1'b0;
    smp();
    if (spine_out_valid[dest[1:0]]) npulse++;
  endtask

  // ---------------- randomized reference model state ----------------
  int          m_cred   [NS];
  int          m_pushed [NS];
  int          m_pops   [NS];
  logic [DW-1:0] m_q    [NS+1][$];   // per-source expected delivery order; NS = loopback
  logic [NS-1:0] m_spv;
  logic [DW-1:0] m_spd  [NS];
  logic        m_hold;
  logic [DW-1:0] m_held;
  int          m_sseq;

  task automatic rand_cycle(input bit active);
    logic [5:0]     d;
    logic [NS-1:0]  cin;
    logic [NS-1:0]  sv;
    logic [NS*DW-1:0] sd;
    logic           fire;
    int             src;
    logic [DW-1:0]  expd;
    cin = '0;
    sv  = '0;
    sd  = '0;
    step();
    if (active) begin
      gpu_out_ready = ($urandom_range(0, 3) != 0);
      d = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 4) == 0) d = 6'd21;
      gpu_in_valid = ($urandom_range(0, 1) == 1);
      gpu_in_data  = {d, 10'($urandom_range(0, 1023))};
      for (int i = 0; i < NS; i++) begin
        cin[i] = (m_cred[i] < CREDITS) && ($urandom_range(0, 2) == 0);
        sv[i]  = ((m_pushed[i] - m_pops[i]) < DEPTH) && ($urandom_range(0, 5) == 0);
        sd[i*DW +: DW] = {4'(i), 12'(m_sseq)};
        m_sseq++;
      end
    end else begin
      gpu_in_valid  = 1'b0;
      gpu_out_ready = 1'b1;
    end
    spine_credit_in = cin;
    spine_in_valid  = sv;
    spine_in_data   = sd;
    smp();

    chk("rnd_spine_valid", 64'(spine_out_valid), 64'(m_spv));
    for (int i = 0; i < NS; i++)
      if (m_spv[i]) chk("rnd_spine_data", 64'(spine_out_data[i*DW +: DW]), 64'(m_spd[i]));

    d = gpu_in_data[DW-1 -: 6];
    if (gpu_in_valid && d != 6'd21)
      chk("rnd_in_ready", 64'(gpu_in_ready), 64'(m_cred[d[1:0]] > 0));
    fire  = gpu_in_valid && gpu_in_ready;
    m_spv = '0;
    if (fire && d != 6'd21) begin
      m_spv[d[1:0]] = 1'b1;
      m_spd[d[1:0]] = gpu_in_data;
      m_cred[d[1:0]]--;
    end
    if (fire && d == 6'd21) m_q[NS].push_back(gpu_in_data);
    for (int i = 0; i < NS; i++) begin
      if (cin[i]) m_cred[i]++;
      if (sv[i]) begin
        m_q[i].push_back(sd[i*DW +: DW]);
        m_pushed[i]++;
      end
      if (spine_credit_out[i]) m_pops[i]++;
    end

    if (m_hold) begin
      chk("rnd_out_held_valid", 64'(gpu_out_valid), 64'd1);
      chk("rnd_out_held_data", 64'(gpu_out_data), 64'(m_held));
    end
    if (gpu_out_valid && gpu_out_ready) begin
      src = (gpu_out_data[DW-1 -: 4] == 4'd5) ? NS : int'(gpu_out_data[DW-1 -: 4]);
      if (src > NS) src = NS;
      expd = 'x;
      if (m_q[src].size() > 0) expd = m_q[src].pop_front();
      chk("rnd_out_data", 64'(gpu_out_data), 64'(expd));
    end
    m_hold = gpu_out_valid && !gpu_out_ready;
    m_held = gpu_out_data;
  endtask

  typedef struct {
    logic [DW-1:0] flit;
    logic [NS-1:0] exp_spv;
    logic          exp_lb;
  } vec_t;

  vec_t vt [7];

  initial begin
    int f, p, cnt;
    int cred_cnt [NS];
    logic [DW-1:0] got [$];
    logic [DW-1:0] g;

    vt[0] = '{flit: 16'h0812, exp_spv: 4'b0100, exp_lb: 1'b0};  // dest 2
    vt[1] = '{flit: 16'h14AB, exp_spv: 4'b0010, exp_lb: 1'b0};  // dest 5
    vt[2] = '{flit: 16'h5400, exp_spv: 4'b0000, exp_lb: 1'b1};  // dest 21, loopback
    vt[3] = '{flit: 16'hFC01, exp_spv: 4'b1000, exp_lb: 1'b0};  // dest 63
    vt[4] = '{flit: 16'h0033, exp_spv: 4'b0001, exp_lb: 1'b0};  // dest 0
    vt[5] = '{flit: 16'h5055, exp_spv: 4'b0001, exp_lb: 1'b0};  // dest 20, next to LOCAL_ID
    vt[6] = '{flit: 16'h5A5A, exp_spv: 4'b0100, exp_lb: 1'b0};  // dest 22, next to LOCAL_ID

    // ---------------- reset state ----------------
    idle_inputs();
    ARESETn      = 1'b0;
    gpu_in_valid = 1'b1;
    gpu_in_data  = 16'h0800;
    step();
    step();
    smp();
    chk("rst_gpu_out_valid", 64'(gpu_out_valid), 64'd0);
    chk("rst_gpu_out_data", 64'(gpu_out_data), 64'd0);
    chk("rst_spine_out_valid", 64'(spine_out_valid), 64'd0);
    chk("rst_spine_out_data", spine_out_data, 64'd0);
    chk("rst_credit_out", 64'(spine_credit_out), 64'd0);
    chk("rst_err", 64'(err_status), 64'd0);
    chk("rst_in_ready", 64'(gpu_in_ready), 64'd0);
    step();
    ARESETn = 1'b1;
    idle_inputs();

    // ---------------- routing table ----------------
    gpu_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      gpu_in_valid = 1'b1;
      gpu_in_data  = vt[i].flit;
      smp();
      chk("vec_ready", 64'(gpu_in_ready), 64'd1);
      step();
      gpu_in_valid = 1'b0;
      smp();
      chk("vec_spine_valid", 64'(spine_out_valid), 64'(vt[i].exp_spv));
      for (int s = 0; s < NS; s++)
        if (vt[i].exp_spv[s]) chk("vec_spine_data", 64'(spine_out_data[s*DW +: DW]), 64'(vt[i].flit));
      chk("vec_gpu_out_none_yet", 64'(gpu_out_valid), 64'd0);
      step();
      smp();
      chk("vec_lb_valid", 64'(gpu_out_valid), 64'(vt[i].exp_lb));
      if (vt[i].exp_lb) chk("vec_lb_data", 64'(gpu_out_data), 64'(vt[i].flit));
      step();
    end

    // ---------------- credit exhaustion on spine 2 ----------------
    do_reset();
    gpu_out_ready = 1'b1;
    send_burst(6'd2, 6, f, p);
    chk("cred_exh_sent", 64'(f), 64'd4);
    chk("cred_exh_pulses", 64'(p), 64'd4);
    step();
    gpu_in_valid    = 1'b1;
    gpu_in_data     = {6'd2, 10'd4};
    spine_credit_in = 4'b0100;
    smp();
    chk("cred_exh_ready_zero", 64'(gpu_in_ready), 64'd0);
    step();
    spine_credit_in = '0;
    smp();
    chk("cred_return_ready", 64'(gpu_in_ready), 64'd1);
    step();
    gpu_in_valid = 1'b0;
    smp();
    chk("cred_fifth_valid", 64'(spine_out_valid), 64'b0100);
    chk("cred_fifth_data", 64'(spine_out_data[2*DW +: DW]), 64'h0804);

    // ---------------- credit overflow ----------------
    do_reset();
    step();
    spine_credit_in = 4'b0001;
    step();
    spine_credit_in = '0;
    smp();
    chk("cred_ovf_err", 64'(err_status), 64'b010);
    send_burst(6'd0, 6, f, p);
    chk("cred_ovf_count_capped", 64'(f), 64'd4);

    // ---------------- fairness ----------------
    do_reset();
    gpu_out_ready = 1'b1;
    step();
    spine_in_valid = 4'hF;
    spine_in_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    step();
    spine_in_valid = '0;
    got.delete();
    for (int i = 0; i < NS; i++) cred_cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      smp();
      if (gpu_out_valid) got.push_back(gpu_out_data);
      for (int i = 0; i < NS; i++) if (spine_credit_out[i]) cred_cnt[i]++;
      step();
    end
    chk("fair_count", 64'(got.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      g = (k < got.size()) ? got[k] : 'x;
      chk("fair_order", 64'(g), 64'(16'hA000 + k));
      chk("fair_credit_out", 64'(cred_cnt[k]), 64'd1);
    end

    // ---------------- ingress overflow on spine 1 ----------------
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      spine_in_valid = 4'b0010;
      spine_in_data  = 64'(16'hB000 + k) << DW;
    end
    step();
    spine_in_valid = '0;
    smp();
    chk("ovf_no_err_at_5", 64'(err_status), 64'd0);
    chk("ovf_out_valid", 64'(gpu_out_valid), 64'd1);
    chk("ovf_out_data", 64'(gpu_out_data), 64'hB000);
    step();
    spine_in_valid = 4'b0010;
    spine_in_data  = 64'(16'hB005) << DW;
    step();
    spine_in_valid = '0;
    smp();
    chk("ovf_err_at_6", 64'(err_status), 64'b001);
    step();
    gpu_out_ready = 1'b1;
    got.delete();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      smp();
      if (gpu_out_valid) got.push_back(gpu_out_data);
      if (spine_credit_out[1]) cnt++;
      step();
    end
    chk("ovf_delivered", 64'(got.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      g = (k < got.size()) ? got[k] : 'x;
      chk("ovf_order", 64'(g), 64'(16'hB000 + k));
    end
    chk("ovf_credit_out", 64'(cnt), 64'd4);

    // ---------------- output backpressure ----------------
    do_reset();
    step();
    spine_in_valid = 4'b1000;
    spine_in_data  = {16'hC003, 48'd0};
    step();
    spine_in_valid = '0;
    step();
    smp();
    chk("bp_latency_valid", 64'(gpu_out_valid), 64'd1);
    chk("bp_latency_data", 64'(gpu_out_data), 64'hC003);
    for (int c = 0; c < 3; c++) begin
      step();
      smp();
      chk("bp_hold_valid", 64'(gpu_out_valid), 64'd1);
      chk("bp_hold_data", 64'(gpu_out_data), 64'hC003);
    end
    step();
    gpu_out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      smp();
      if (gpu_out_valid && gpu_out_ready) cnt++;
      step();
    end
    chk("bp_delivered_once", 64'(cnt), 64'd1);

    // ---------------- reset mid-stream ----------------
    do_reset();
    step();
    spine_in_valid = 4'b0111;
    spine_in_data  = {16'h0, 16'hD002, 16'hD001, 16'hD000};
    gpu_in_valid   = 1'b1;
    gpu_in_data    = 16'h0801;
    step();
    spine_in_valid = '0;
    gpu_in_data    = 16'h0802;
    step();
    ARESETn = 1'b0;
    step();
    smp();
    chk("midrst_gpu_out_valid", 64'(gpu_out_valid), 64'd0);
    chk("midrst_gpu_out_data", 64'(gpu_out_data), 64'd0);
    chk("midrst_spine_valid", 64'(spine_out_valid), 64'd0);
    chk("midrst_spine_data", spine_out_data, 64'd0);
    chk("midrst_credit_out", 64'(spine_credit_out), 64'd0);
    chk("midrst_in_ready", 64'(gpu_in_ready), 64'd0);
    chk("midrst_err", 64'(err_status), 64'd0);
    step();
    ARESETn       = 1'b1;
    gpu_in_valid  = 1'b0;
    gpu_out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      smp();
      if (gpu_out_valid || (spine_credit_out != '0)) cnt++;
      step();
    end
    chk("midrst_discarded", 64'(cnt), 64'd0);
    send_burst(6'd2, 6, f, p);
    chk("midrst_credits_restored", 64'(f), 64'd4);

    // ---------------- randomized run ----------------
    do_reset();
    for (int i = 0; i < NS; i++) begin
      m_cred[i]   = CREDITS;
      m_pushed[i] = 0;
      m_pops[i]   = 0;
    end
    for (int i = 0; i <= NS; i++) m_q[i].delete();
    m_spv  = '0;
    m_hold = 1'b0;
    m_held = '0;
    m_sseq = 0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 60; c++) rand_cycle(1'b0);
    for (int i = 0; i <= NS; i++) chk("rnd_queue_drained", 64'(m_q[i].size()), 64'd0);
    for (int i = 0; i < NS; i++) chk("rnd_credit_out_total", 64'(m_pops[i]), 64'(m_pushed[i]));
    chk("rnd_no_errors", 64'(err_status), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
